// File: rtl/lcd_reader.sv
// ============================================================================
//  Module   : lcd_reader
//  Purpose  : HD44780-style LCD read cycle (RS/RW setup, E strobe, hold) as a
//             custom-instruction slave. LCD_BUSY_POLL_EN adds busy-flag polling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_reader #(
    parameter int T_SETUP  = 4,
    parameter int T_PULSE  = 25,
    parameter int T_HOLD   = 4,
    parameter int POLL_MAX = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    input  logic [7:0]  lcd_data_in,
    output logic        rd_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] c_setup_last = 8'(T_SETUP - 1);
    localparam logic [7:0] c_pulse_last = 8'(T_PULSE - 1);
    localparam logic [7:0] c_hold_last  = 8'(T_HOLD - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_rs;
    logic        r_en;
    logic        r_active;
    logic        r_done;
    logic [7:0]  r_byte;
    logic [31:0] r_result;
    logic        w_retry;
    logic        w_timeout;
    logic        w_unused;

`ifdef LCD_BUSY_POLL_EN
    logic        r_poll;
    logic [15:0] r_attempts;

    // Only status reads (RS=0) are polled; r_attempts already counts the read just finished.
    assign w_retry   = r_poll && !r_rs && r_byte[7] && (r_attempts < 16'(POLL_MAX));
    assign w_timeout = r_poll && !r_rs && r_byte[7];
    assign w_unused  = ^{datab, dataa[31:2]};
`else
    assign w_retry   = 1'b0;
    assign w_timeout = 1'b0;
    assign w_unused  = ^{datab, dataa[31:1]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (start) w_state_nxt = SETUP;
            end
            SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            PULSE: begin
                if (r_cnt == c_pulse_last) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = w_retry ? SETUP : DONE;
                    w_cnt_nxt   = '0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so the pins never glitch on state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs     <= 1'b0;
            r_en     <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_byte   <= '0;
            r_result <= '0;
`ifdef LCD_BUSY_POLL_EN
            r_poll     <= 1'b0;
            r_attempts <= '0;
`endif
        end else if (clk_en) begin
            r_en     <= (w_state_nxt == PULSE);
            r_active <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == DONE);
            if (r_state == IDLE && start) begin
                r_rs <= dataa[0];
`ifdef LCD_BUSY_POLL_EN
                r_poll     <= dataa[1];
                r_attempts <= '0;
`endif
            end
            if (r_state == PULSE && r_cnt == c_pulse_last) begin
                r_byte <= lcd_data_in;
`ifdef LCD_BUSY_POLL_EN
                r_attempts <= r_attempts + 16'd1;
`endif
            end
            if (w_state_nxt == DONE) begin
                r_result <= {23'd0, w_timeout, r_byte};
            end
        end
    end

    assign lcd_rs    = r_rs;
    assign lcd_rw    = r_active;
    assign lcd_en    = r_en;
    assign rd_active = r_active;
    assign done      = r_done;
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_lcd_reader.sv
// ============================================================================
//  Module   : tb_lcd_reader
//  Purpose  : Scoreboard bench for lcd_reader: directed and random reads,
//             checked against a read-count model of the LCD protocol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_reader;

    localparam int TS = 4;
    localparam int TP = 25;
    localparam int TH = 4;
    localparam int PM = 5;
`ifdef LCD_BUSY_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [7:0]  lcd_data_in = '0;
    logic [31:0] result;
    logic        done, lcd_rs, lcd_rw, lcd_en, rd_active;

    lcd_reader #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .POLL_MAX(PM)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .result(result), .done(done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .rd_active(rd_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          pulses;
        longint      done_cyc;
        int          stall;
        logic        rs;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  tb_bytes [8];
    int          total = 0;
    int          bad = 0;
    longint      cyc = 0;
    bit          aborting = 1'b0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: supplies LCD bytes on each E rise, measures strobe timing, pops on done.
    bit en_prev = 1'b0;
    int hi = 0, lo = 0, npulse = 0, rd_idx = 0;

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no transaction pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("pulse_count", npulse, e.pulses);
                check("done_cycle", cyc, e.done_cyc);
            end
        end
        if (reset || aborting) begin
            en_prev = 1'b0; hi = 0; lo = 0; npulse = 0; rd_idx = 0;
        end else begin
            if (!rd_active) begin
                rd_idx = 0; npulse = 0; lo = 0;
            end
            if (lcd_en && !en_prev) begin
                lcd_data_in = tb_bytes[rd_idx];
                if (rd_idx < 7) rd_idx++;
                if (q.size() > 0) begin
                    check("setup_gap", lo, (npulse == 0) ? TS : TH + TS);
                    check("rs_in_read", lcd_rs, q[0].rs);
                    check("rw_in_read", lcd_rw, 1);
                end
                hi = 0;
            end
            if (lcd_en) hi++;
            if (!lcd_en && en_prev) begin
                if (q.size() > 0)
                    check("e_width", hi, (npulse == 0) ? TP + q[0].stall : TP);
                npulse++;
                lo = 0;
            end
            if (rd_active && !lcd_en) lo++;
            en_prev = lcd_en;
        end
    end

    task automatic run_txn(input logic rs, input logic poll, input int stall_at,
                           input int stall_len, input bit dbl);
        exp_t e;
        int   n;
        int   k;
        bit   pe;
        check("result_hold", result, last_res);
        // Reference: number of reads follows from the busy bytes the LCD returns.
        pe = POLL_ON && poll && !rs;
        n = 1;
        while (pe && tb_bytes[n-1][7] && n < PM) n++;
        e.res      = {23'd0, pe && tb_bytes[n-1][7], tb_bytes[n-1]};
        e.pulses   = n;
        e.stall    = stall_len;
        e.rs       = rs;
        e.done_cyc = cyc + 1 + n * (TS + TP + TH) + stall_len;
        q.push_back(e);
        dataa = ($urandom() & 32'hFFFF_FFFC) | {30'd0, poll, rs};
        datab = $urandom();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (dbl) begin
            @(negedge clk);
            dataa = $urandom();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (stall_len > 0) begin
            k = 0;
            while (!lcd_en && k < 200) begin
                @(negedge clk);
                k++;
            end
            repeat (stall_at) @(negedge clk);
            clk_en = 1'b0;
            repeat (stall_len) @(negedge clk);
            clk_en = 1'b1;
        end
        k = 0;
        while (q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
            q.delete();
        end
        last_res = e.res;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_abort();
        int k;
        for (int i = 0; i < 8; i++) tb_bytes[i] = 8'h77;
        dataa = 32'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!lcd_en && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (11) @(negedge clk);
        aborting = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_en", lcd_en, 0);
        check("abort_rw", lcd_rw, 0);
        check("abort_active", rd_active, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        aborting = 1'b0;
        last_res = '0;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tb_bytes[i] = 8'h00;
        reset = 1'b1;
        start = 1'b1;
        dataa = 32'h3;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("rst_en", lcd_en, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_active", rd_active, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        tb_bytes = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b1, 1'b0, 0, 0, 1'b0);

        tb_bytes = '{8'h83, 8'h83, 8'h83, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b0, 1'b1, 0, 0, 1'b0);

        tb_bytes = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run_txn(1'b0, 1'b1, 0, 0, 1'b0);

        tb_bytes = '{8'hC1, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b1, 1'b1, 0, 0, 1'b0);

        tb_bytes = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b1, 1'b0, 11, 10, 1'b0);

        run_abort();

        tb_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(1'b0, 1'b0, 0, 0, 1'b1);

        for (int t = 0; t < 20; t++) begin
            int  busy;
            int  st_at, st_len;
            bit  dbl;
            busy = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++)
                tb_bytes[i] = (i < busy) ? (8'h80 | 8'($urandom())) : (8'h7F & 8'($urandom()));
            st_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            st_at  = $urandom_range(1, 20);
            dbl    = ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st_at, st_len, dbl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_SETUP, default 4: cycles that RS/RW are stable before E rises (valid range 1..255).
REQ-002 Parameter T_PULSE, default 25: cycles that E stays high (500 ns at 50 MHz; valid range 2..255).
REQ-003 Parameter T_HOLD, default 4: cycles after E falls before the read completes (valid range 1..255).
REQ-004 Parameter POLL_MAX, default 1000: maximum reads per busy-poll transaction (valid range 1..65535).
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  custom-instruction clock enable; when 0, the FSM and counters freeze.
REQ-008 start  in  1  custom-instruction start; sampled only in IDLE with clk_en=1.
REQ-009 dataa  in  32  bit0 = RS value; bit1 = poll request; bits 31:2 ignored.
REQ-010 datab  in  32  unused; ignored.
REQ-011 result  out  32  bits 7:0 = sampled LCD byte; bit8 = poll timeout; bits 31:9 = 0.
REQ-012 done  out  1  one-cycle pulse; result is valid in the same cycle.
REQ-013 lcd_rs  out  1  LCD register select.
REQ-014 lcd_rw  out  1  LCD R/W; 1 only during a read transaction.
REQ-015 lcd_en  out  1  LCD enable strobe.
REQ-016 lcd_data_in  in  8  LCD DB7..DB0 as seen by the FPGA.
REQ-017 rd_active  out  1  high while a transaction is in progress; the top level tri-states the write path when it is high.

Function
REQ-018 The FSM states shall be IDLE, SETUP, PULSE, HOLD and DONE; one state shall advance per enabled cycle.
REQ-019 IDLE: on start=1 with clk_en=1, the block shall latch dataa[0] to lcd_rs, latch dataa[1] to the poll flag, set lcd_rw=1 and rd_active=1, clear the attempt counter, and go to SETUP.
REQ-020 SETUP: lcd_en shall be 0 for exactly T_SETUP enabled cycles, then the block shall go to PULSE.
REQ-021 PULSE: lcd_en shall be 1 for exactly T_PULSE enabled cycles; lcd_data_in shall be captured on the last PULSE cycle, before E falls.
REQ-022 HOLD: lcd_en shall be 0 and lcd_rw=1 for T_HOLD enabled cycles, and the attempt counter shall increment once.
REQ-023 At the end of HOLD, if the poll flag=1, lcd_rs=0, the captured bit7=1 and attempts<POLL_MAX, the block shall return to SETUP; otherwise it shall go to DONE.
REQ-024 DONE shall last one cycle, with done=1, result[7:0]=captured byte, and result[8]=1 only if the poll exhausted POLL_MAX while bit7 was still 1; the block shall then go to IDLE with lcd_rw=0 and rd_active=0.
REQ-025 Single-read latency from the start edge to the done pulse shall be T_SETUP+T_PULSE+T_HOLD+1 enabled cycles (34 with default parameters).
REQ-026 result shall hold its value until the next DONE; done shall be 0 in every other state.
REQ-027 start asserted outside IDLE shall be ignored, with no queuing.
REQ-028 With clk_en=0, all state, counters and outputs shall hold, including lcd_en.
REQ-029 If the poll flag=1 with lcd_rs=1, the block shall perform a single data read with no polling.

Reset
REQ-030 reset=1 shall override clk_en and start in the same cycle.
REQ-031 Reset values shall be: state IDLE; lcd_en=0; lcd_rw=0; lcd_rs=0; rd_active=0; done=0; result=0; all counters 0.
REQ-032 Reset mid-transaction shall drop lcd_en on the next edge, abort with no done pulse, and leave result=0.

Configuration
REQ-033 Macro LCD_BUSY_POLL_EN defined: busy-flag polling per REQ-023 and REQ-029 shall be compiled in.
REQ-034 Macro LCD_BUSY_POLL_EN undefined: dataa[1] shall be ignored, every transaction shall be a single read, result[8]=0, and the poll and attempt logic shall be absent.

Verification
REQ-035 Single read, default parameters: reset, then start with dataa=1 and lcd_data_in=0x5A -> lcd_rw rises with the start edge, lcd_en is high for exactly 25 cycles after a 4-cycle setup, done occurs 34 cycles after start, result=0x0000005A.
REQ-036 Poll (macro defined): dataa=2, lcd_data_in=0x83 for the first 3 reads then 0x03 -> 4 E pulses, done once, result=0x00000003, result[8]=0.
REQ-037 Poll timeout with POLL_MAX=5: dataa=2, lcd_data_in fixed at 0x80 -> exactly 5 E pulses, result=0x00000180.
REQ-038 clk_en low for 10 cycles in the middle of PULSE -> the lcd_en high phase is 35 clock cycles, and done is delayed by 10 cycles.
REQ-039 reset asserted on PULSE cycle 12 -> lcd_en=0, lcd_rw=0 and rd_active=0 on the next edge, no done pulse, result=0; the next start completes normally.
REQ-040 Second start during SETUP -> ignored; exactly one done pulse and one E pulse.
